threshold_reset_unit: RTL and testbench

THRESHOLD_RESET_UNIT -- requirements
Module: threshold_reset_unit

---
 rtl/threshold_reset_unit.sv | 65 ++++++
 tb/tb_threshold_reset_unit.sv | 111 +++++++++++
 2 files changed

// File: rtl/threshold_reset_unit.sv
// Threshold/reset stage of a spiking neuron: fires on a (optionally jittered) positive
// threshold, clamps to a floor on the negative threshold, otherwise passes the potential.
module threshold_reset_unit #(
  parameter logic [7:0] POS_THRESHOLD = 8'h80,
  parameter logic [7:0] NEG_THRESHOLD = 8'h40,
  parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] membrane_potential,
  input  logic [1:0] pos_neg_thresholds,
  input  logic       mask,
  input  logic [7:0] v_reset,
  output logic       threshold_output,
  output logic [7:0] reset_membrane_potential
);

  logic [7:0] r_lfsr;
  logic       w_fb;
  logic       w_eta;
  logic [8:0] w_pos_sum;
  logic [7:0] w_pos_thr;
  logic       w_pos_cross;
  logic       w_neg_cross;
  logic       w_spike;
  logic [7:0] w_vm_next;

  // x^8+x^6+x^5+x^4+1: taps on bits 7,5,4,3, shifting toward the MSB
  assign w_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

  always_ff @(posedge clk) begin
    if (rst) r_lfsr <= LFSR_SEED;
    else     r_lfsr <= {r_lfsr[6:0], w_fb};
  end

  assign w_eta     = r_lfsr[0] & mask;
  assign w_pos_sum = {1'b0, POS_THRESHOLD} + {8'd0, w_eta};
  // Saturate so a 8'hFF threshold plus jitter never wraps to zero
  assign w_pos_thr = w_pos_sum[8] ? 8'hFF : w_pos_sum[7:0];

  assign w_pos_cross = pos_neg_thresholds[0] && (membrane_potential >= w_pos_thr);
  assign w_neg_cross = pos_neg_thresholds[1] && (membrane_potential < NEG_THRESHOLD);

  always_comb begin
    w_spike   = 1'b0;
    w_vm_next = membrane_potential;
    if (w_pos_cross) begin
      w_spike   = 1'b1;
      w_vm_next = v_reset;
    end else if (w_neg_cross) begin
      w_vm_next = NEG_THRESHOLD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      threshold_output         <= 1'b0;
      reset_membrane_potential <= 8'h00;
    end else begin
      threshold_output         <= w_spike;
      reset_membrane_potential <= w_vm_next;
    end
  end

endmodule

// File: tb/tb_threshold_reset_unit.sv
// Directed + randomized bench for threshold_reset_unit against an arithmetic reference model.
module tb_threshold_reset_unit;

  localparam logic [7:0] POS  = 8'h80;
  localparam logic [7:0] NEG  = 8'h40;
  localparam logic [7:0] SEED = 8'hA5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] membrane_potential = 8'h00;
  logic [1:0] pos_neg_thresholds = 2'b00;
  logic       mask = 1'b0;
  logic [7:0] v_reset = 8'h00;
  logic       threshold_output;
  logic [7:0] reset_membrane_potential;

  int pass_cnt = 0;
  int total    = 0;
  logic [7:0] m_lfsr = SEED;

  threshold_reset_unit #(
    .POS_THRESHOLD(POS), .NEG_THRESHOLD(NEG), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .rst(rst),
    .membrane_potential(membrane_potential),
    .pos_neg_thresholds(pos_neg_thresholds),
    .mask(mask), .v_reset(v_reset),
    .threshold_output(threshold_output),
    .reset_membrane_potential(reset_membrane_potential)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    // feedback is the parity of the tapped bits (exponents 8,6,5,4)
    return {s[6:0], ^(s & 8'hB8)};
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    total = total + 1;
    assert (obs === exp) pass_cnt = pass_cnt + 1;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Apply inputs, clock once, and compare both outputs against the model
  task automatic step(input logic r, input logic [1:0] pn, input logic m,
                      input logic [7:0] mp, input logic [7:0] vr, input string tag);
    int  thr;
    int  exp_vm;
    logic exp_t;
    rst = r; pos_neg_thresholds = pn; mask = m;
    membrane_potential = mp; v_reset = vr;
    @(posedge clk);
    if (r) begin
      exp_t = 1'b0; exp_vm = 0; m_lfsr = SEED;
    end else begin
      thr = int'(POS) + int'(m_lfsr[0] & m);
      if (thr > 255) thr = 255;
      exp_t = 1'b0; exp_vm = int'(mp);
      if (pn[0] && int'(mp) >= thr) begin
        exp_t = 1'b1; exp_vm = int'(vr);
      end else if (pn[1] && mp < NEG) begin
        exp_vm = int'(NEG);
      end
      m_lfsr = lfsr_next(m_lfsr);
    end
    #1;
    check({tag, ".spk"}, int'(threshold_output), int'(exp_t));
    check({tag, ".vm"},  int'(reset_membrane_potential), exp_vm);
  endtask

  initial begin
    step(1'b1, 2'b11, 1'b1, 8'hFF, 8'h11, "reset0");
    step(1'b1, 2'b11, 1'b1, 8'hFF, 8'h11, "reset1");
    check("reset_literal_vm", int'(reset_membrane_potential), 0);

    step(1'b0, 2'b01, 1'b0, 8'h70, 8'h00, "below");
    step(1'b0, 2'b01, 1'b0, 8'h90, 8'h00, "fire_vr00");
    check("fire_literal", int'(threshold_output), 1);
    step(1'b0, 2'b01, 1'b0, 8'h90, 8'h20, "fire_vr20");
    step(1'b0, 2'b01, 1'b0, 8'h90, 8'h20, "fire_level");
    step(1'b0, 2'b01, 1'b0, 8'h80, 8'h33, "bnd_pos_eta0");

    for (int i = 0; i < 8; i++) step(1'b0, 2'b01, 1'b1, 8'h90, 8'h05, "jit_90");
    for (int i = 0; i < 16; i++) step(1'b0, 2'b01, 1'b1, 8'h80, 8'h05, "jit_80");

    step(1'b0, 2'b10, 1'b0, 8'h50, 8'h00, "neg_pass");
    step(1'b0, 2'b10, 1'b0, 8'h30, 8'h00, "neg_clamp");
    check("neg_literal", int'(reset_membrane_potential), 8'h40);
    step(1'b0, 2'b10, 1'b1, 8'h40, 8'h00, "bnd_neg40");
    step(1'b0, 2'b10, 1'b1, 8'h3F, 8'h00, "bnd_neg3F");

    step(1'b0, 2'b00, 1'b1, 8'hFF, 8'h12, "dis_FF");
    step(1'b0, 2'b00, 1'b1, 8'h00, 8'h12, "dis_00");
    step(1'b0, 2'b11, 1'b0, 8'h3F, 8'h77, "both_3F");
    step(1'b0, 2'b11, 1'b0, 8'h40, 8'h77, "both_40");
    step(1'b0, 2'b11, 1'b0, 8'h80, 8'h77, "both_80");

    step(1'b1, 2'b01, 1'b0, 8'hFF, 8'h77, "midrst");
    // LFSR reloads from seed: first post-reset cycle sees lfsr[0]=1, so 80 must not fire
    step(1'b0, 2'b01, 1'b1, 8'h80, 8'h77, "bnd_pos_eta1");

    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 31) == 0), 2'($urandom), 1'($urandom),
           8'($urandom), 8'($urandom), "rand");

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
